// File: rtl/apb_mas_ctrl_if.sv
// Command, response and APB bus bundle for the APB master controller.
// master = controller side, slave = sequencer plus APB slaves side.
interface apb_mas_ctrl_if #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int SW      = DW/8,
  parameter int NUM_SLV = 4
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [AW-1:0]     cmd_addr;
  logic [DW-1:0]     cmd_wdata;
  logic [SW-1:0]     cmd_strb;
  logic [2:0]        cmd_prot;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DW-1:0]     rsp_rdata;
  logic              rsp_err;
  logic              rsp_timeout;
  logic [NUM_SLV-1:0] PSEL;
  logic              PENABLE;
  logic [AW-1:0]     PADDR;
  logic [DW-1:0]     PWDATA;
  logic              PWRITE;
  logic [SW-1:0]     PSTROB;
  logic [2:0]        PPROT;
  logic [NUM_SLV*DW-1:0] PRDATA;
  logic [NUM_SLV-1:0] PREADY;
  logic [NUM_SLV-1:0] PSLVERR;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr,
    input  cmd_wdata, cmd_strb, cmd_prot,
    output cmd_ready,
    output rsp_valid, rsp_rdata,
    output rsp_err, rsp_timeout,
    input  rsp_ready,
    output PSEL, PENABLE, PADDR, PWDATA,
    output PWRITE, PSTROB, PPROT,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr,
    output cmd_wdata, cmd_strb, cmd_prot,
    input  cmd_ready,
    input  rsp_valid, rsp_rdata,
    input  rsp_err, rsp_timeout,
    output rsp_ready,
    input  PSEL, PENABLE, PADDR, PWDATA,
    input  PWRITE, PSTROB, PPROT,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/apb_mas_ctrl.sv
// APB master controller: command FIFO feeding a SETUP/ACCESS/RESP
// sequencer that drives one of NUM_SLV slaves and returns responses.
module apb_mas_ctrl #(
  parameter int APB_ADDR_WIDTH  = 32,
  parameter int APB_DATA_WIDTH  = 32,
  parameter int APB_STROB_WIDTH = APB_DATA_WIDTH/8,
  parameter int NUM_SLV         = 4,
  parameter int SLV_SEL_LSB     = 12,
  parameter int CMD_DEPTH       = 4,
  parameter int TIMEOUT         = 16
) (
  input logic            clk,
  input logic            rstn,
  apb_mas_ctrl_if.master bus
);
  localparam int AW   = APB_ADDR_WIDTH;
  localparam int DW   = APB_DATA_WIDTH;
  localparam int SW   = APB_STROB_WIDTH;
  localparam int SELW = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;
  localparam int PW   = $clog2(CMD_DEPTH);
  localparam int CW   = PW + 1;
  localparam int TW   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef struct packed {
    logic          write;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [SW-1:0] strb;
    logic [2:0]    prot;
  } cmd_t;

  typedef enum logic [1:0] {
    IDLE, SETUP, ACCESS, RESP
  } state_t;

  cmd_t          mem_q [CMD_DEPTH];
  cmd_t          cmd_in;
  cmd_t          head;
  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          rdy_q, rdy_d;
  logic          push, pop;
  logic          dispatch;

  state_t        st_q, st_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [SELW-1:0] idx_q, idx_d;
  logic [SELW-1:0] head_idx;
  logic          head_bad;

  logic [AW-1:0] paddr_q, paddr_d;
  logic [DW-1:0] pwdata_q, pwdata_d;
  logic          pwrite_q, pwrite_d;
  logic [SW-1:0] pstrb_q, pstrb_d;
  logic [2:0]    pprot_q, pprot_d;

  logic [DW-1:0] rdata_q, rdata_d;
  logic          err_q, err_d;
  logic          tout_q, tout_d;

  logic [NUM_SLV-1:0] psel;
  logic          sel_rdy, sel_err;
  logic [DW-1:0] sel_rdata;
  logic          timed_out;

  assign cmd_in = '{
    write: bus.cmd_write,
    addr:  bus.cmd_addr,
    wdata: bus.cmd_wdata,
    strb:  bus.cmd_strb,
    prot:  bus.cmd_prot
  };

  assign push     = bus.cmd_valid && rdy_q;
  assign head     = mem_q[rptr_q];
  assign head_idx = head.addr[SLV_SEL_LSB +: SELW];
  assign head_bad = 32'(head_idx) >= 32'(NUM_SLV);

  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= cmd_in;
  end

  always_comb begin
    wptr_d = wptr_q + PW'(push);
    rptr_d = rptr_q + PW'(pop);
    cnt_d  = cnt_q;
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
    rdy_d = cnt_d != CW'(CMD_DEPTH);
  end

  // Only the addressed slave's handshake is ever looked at.
  always_comb begin
    psel      = '0;
    sel_rdy   = 1'b0;
    sel_err   = 1'b0;
    sel_rdata = '0;
    for (int i = 0; i < NUM_SLV; i++) begin
      if (idx_q == SELW'(i)) begin
        psel[i]   = (st_q == SETUP) ||
                    (st_q == ACCESS);
        sel_rdy   = bus.PREADY[i];
        sel_err   = bus.PSLVERR[i];
        sel_rdata = bus.PRDATA[i*DW +: DW];
      end
    end
  end

  assign timed_out = (TIMEOUT != 0) &&
                     (tmo_q == TW'(TIMEOUT - 1));

  always_comb begin
    st_d     = st_q;
    tmo_d    = tmo_q;
    idx_d    = idx_q;
    paddr_d  = paddr_q;
    pwdata_d = pwdata_q;
    pwrite_d = pwrite_q;
    pstrb_d  = pstrb_q;
    pprot_d  = pprot_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    tout_d   = tout_q;
    pop      = 1'b0;
    dispatch = 1'b0;
    unique case (st_q)
      IDLE: dispatch = cnt_q != '0;
      SETUP: begin
        st_d  = ACCESS;
        tmo_d = '0;
      end
      ACCESS: begin
        if (sel_rdy) begin
          st_d    = RESP;
          rdata_d = (pwrite_q || sel_err) ?
                    '0 : sel_rdata;
          err_d   = sel_err;
          tout_d  = 1'b0;
        end else if (timed_out) begin
          st_d    = RESP;
          rdata_d = '0;
          err_d   = 1'b1;
          tout_d  = 1'b1;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          st_d     = IDLE;
          dispatch = cnt_q != '0;
        end
      end
      default: st_d = IDLE;
    endcase
    // An out-of-range slave index answers without touching the bus.
    if (dispatch) begin
      pop = 1'b1;
      if (head_bad) begin
        st_d    = RESP;
        rdata_d = '0;
        err_d   = 1'b1;
        tout_d  = 1'b0;
      end else begin
        st_d     = SETUP;
        idx_d    = head_idx;
        paddr_d  = head.addr;
        pwdata_d = head.wdata;
        pwrite_d = head.write;
        pstrb_d  = head.write ? head.strb : '0;
        pprot_d  = head.prot;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rstn) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      cnt_q    <= '0;
      rdy_q    <= 1'b0;
      st_q     <= IDLE;
      tmo_q    <= '0;
      idx_q    <= '0;
      paddr_q  <= '0;
      pwdata_q <= '0;
      pwrite_q <= 1'b0;
      pstrb_q  <= '0;
      pprot_q  <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      tout_q   <= 1'b0;
    end else begin
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      cnt_q    <= cnt_d;
      rdy_q    <= rdy_d;
      st_q     <= st_d;
      tmo_q    <= tmo_d;
      idx_q    <= idx_d;
      paddr_q  <= paddr_d;
      pwdata_q <= pwdata_d;
      pwrite_q <= pwrite_d;
      pstrb_q  <= pstrb_d;
      pprot_q  <= pprot_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
      tout_q   <= tout_d;
    end
  end

  assign bus.cmd_ready   = rdy_q;
  assign bus.rsp_valid   = st_q == RESP;
  assign bus.rsp_rdata   = rdata_q;
  assign bus.rsp_err     = err_q;
  assign bus.rsp_timeout = tout_q;
  assign bus.PSEL        = psel;
  assign bus.PENABLE     = st_q == ACCESS;
  assign bus.PADDR       = paddr_q;
  assign bus.PWDATA      = pwdata_q;
  assign bus.PWRITE      = pwrite_q;
  assign bus.PSTROB      = pstrb_q;
  assign bus.PPROT       = pprot_q;
endmodule

// File: tb/tb_apb_mas_ctrl.sv
// Scoreboard bench for apb_mas_ctrl: directed commands, modelled
// slaves with wait states/errors/hangs, monitor-side response checks.
module tb_apb_mas_ctrl;
  logic clk = 1'b0;
  logic rstn;

  always #5 clk = ~clk;

  apb_mas_ctrl_if #(
    .AW(32), .DW(32), .SW(4), .NUM_SLV(4)
  ) bus ();

  apb_mas_ctrl #(
    .APB_ADDR_WIDTH(32),
    .APB_DATA_WIDTH(32),
    .APB_STROB_WIDTH(4),
    .NUM_SLV(4),
    .SLV_SEL_LSB(12),
    .CMD_DEPTH(4),
    .TIMEOUT(16)
  ) dut (
    .clk(clk),
    .rstn(rstn),
    .bus(bus)
  );

  typedef struct {
    logic [3:0]  psel;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic        wr;
    int          acc;
    logic [31:0] rdata;
    logic        err;
    logic        tmo;
  } exp_t;

  exp_t exp_q[$];
  int total = 0;
  int bad   = 0;

  // slave model configuration
  int          wait_cfg [4];
  logic [31:0] rd_cfg   [4];
  logic [3:0]  hang;
  logic [3:0]  err_cfg;
  logic        noise;
  int          acc_c;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h",
               nm, act, req);
    end
  endtask

  always @(posedge clk) begin
    if (rstn) acc_c <= 0;
    else acc_c <= bus.PENABLE ? acc_c + 1 : 0;
  end

  // Unselected slaves drive ready/error high to expose bad muxing.
  always_comb begin
    bus.PREADY  = '0;
    bus.PSLVERR = '0;
    bus.PRDATA  = '0;
    for (int i = 0; i < 4; i++) begin
      if (bus.PSEL[i] && bus.PENABLE) begin
        bus.PREADY[i]  = !hang[i] &&
                         (acc_c >= wait_cfg[i]);
        bus.PSLVERR[i] = err_cfg[i];
      end else begin
        bus.PREADY[i]  = noise;
        bus.PSLVERR[i] = noise;
      end
      bus.PRDATA[i*32 +: 32] = rd_cfg[i];
    end
  end

  // monitor
  logic [3:0]  s_psel;
  logic [31:0] s_addr, s_wdata;
  logic [3:0]  s_strb;
  logic        s_wr;
  int          acc_n;
  logic        hs_prev;

  always @(negedge clk) begin
    if (rstn) begin
      hs_prev = 1'b0;
      acc_n   = 0;
    end else begin
      if (hs_prev && exp_q.size() != 0)
        chk("b2b_setup",
            {62'd0, bus.PSEL != 0, bus.PENABLE},
            64'd2);
      hs_prev = 1'b0;
      if (bus.PSEL != 0 && !bus.PENABLE) begin
        s_psel  = bus.PSEL;
        s_addr  = bus.PADDR;
        s_wdata = bus.PWDATA;
        s_strb  = bus.PSTROB;
        s_wr    = bus.PWRITE;
        acc_n   = 0;
      end
      if (bus.PENABLE) begin
        acc_n++;
        chk("hold_psel", 64'(bus.PSEL), 64'(s_psel));
        chk("hold_addr", 64'(bus.PADDR), 64'(s_addr));
      end
      if (bus.rsp_valid && bus.rsp_ready) begin
        hs_prev = 1'b1;
        if (exp_q.size() == 0) begin
          chk("unexpected_rsp", 64'd1, 64'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("psel",  64'(s_psel),  64'(e.psel));
          chk("paddr", 64'(s_addr),  64'(e.addr));
          chk("pwdata", 64'(s_wdata), 64'(e.wdata));
          chk("pstrob", 64'(s_strb), 64'(e.strb));
          chk("pwrite", 64'(s_wr),   64'(e.wr));
          chk("acc_cycles", 64'(acc_n), 64'(e.acc));
          chk("rdata", 64'(bus.rsp_rdata), 64'(e.rdata));
          chk("err",   64'(bus.rsp_err),   64'(e.err));
          chk("tmo",   64'(bus.rsp_timeout), 64'(e.tmo));
          chk("rsp_bus_idle",
              {59'd0, bus.PSEL, bus.PENABLE}, 64'd0);
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic exp_t mk(
    input logic [3:0] ps, input logic [31:0] a,
    input logic [31:0] wd, input logic [3:0] st,
    input logic wr, input int acc,
    input logic [31:0] rd, input logic er,
    input logic tm);
    exp_t e;
    e.psel = ps; e.addr = a; e.wdata = wd;
    e.strb = st; e.wr = wr; e.acc = acc;
    e.rdata = rd; e.err = er; e.tmo = tm;
    return e;
  endfunction

  task automatic send(
    input logic wr, input logic [31:0] a,
    input logic [31:0] wd, input logic [3:0] st,
    input logic [2:0] pr, input exp_t e);
    int n = 0;
    exp_q.push_back(e);
    bus.cmd_valid = 1'b1;
    bus.cmd_write = wr;
    bus.cmd_addr  = a;
    bus.cmd_wdata = wd;
    bus.cmd_strb  = st;
    bus.cmd_prot  = pr;
    while (!bus.cmd_ready && n < 100) begin
      cyc();
      n++;
    end
    if (n >= 100) chk("cmd_ready_to", 64'(bus.cmd_ready), 64'd1);
    cyc();
    bus.cmd_valid = 1'b0;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      cyc();
      n++;
    end
    chk("drain_left", 64'(exp_q.size()), 64'd0);
    cyc();
  endtask

  initial begin
    int n;
    int seen;
    rstn = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_wdata = '0;
    bus.cmd_strb  = '0;
    bus.cmd_prot  = '0;
    bus.rsp_ready = 1'b0;
    hang = '0; err_cfg = '0; noise = 1'b1;
    for (int i = 0; i < 4; i++) wait_cfg[i] = 0;
    rd_cfg[0] = 32'hA0A0_0000;
    rd_cfg[1] = 32'hB1B1_1111;
    rd_cfg[2] = 32'h1234_5678;
    rd_cfg[3] = 32'hC3C3_3333;

    repeat (3) cyc();
    chk("rst_cmd_ready", 64'(bus.cmd_ready), 64'd0);
    chk("rst_bus", {59'd0, bus.PSEL, bus.PENABLE}, 64'd0);
    chk("rst_rsp", 64'(bus.rsp_valid), 64'd0);
    chk("rst_paddr", 64'(bus.PADDR), 64'd0);
    rstn = 1'b0;
    cyc();
    chk("post_rst_ready", 64'(bus.cmd_ready), 64'd1);
    bus.rsp_ready = 1'b1;

    // 1: write slave 1, latency SETUP@1 ACCESS@2 RESP@3
    send(1'b1, 32'h0000_1004, 32'hDEAD_BEEF, 4'hF, 3'd2,
         mk(4'b0010, 32'h0000_1004, 32'hDEAD_BEEF, 4'hF,
            1'b1, 1, 32'h0, 1'b0, 1'b0));
    @(negedge clk);
    chk("lat_idle", 64'(bus.PSEL), 64'd0);
    @(negedge clk);
    chk("lat_setup", {59'd0, bus.PSEL, bus.PENABLE},
        {59'd0, 4'b0010, 1'b0});
    @(negedge clk);
    chk("lat_access", {59'd0, bus.PSEL, bus.PENABLE},
        {59'd0, 4'b0010, 1'b1});
    @(negedge clk);
    chk("lat_resp", 64'(bus.rsp_valid), 64'd1);
    drain(20);
    chk("idle_paddr_hold", 64'(bus.PADDR), 64'h1004);
    chk("idle_pprot_hold", 64'(bus.PPROT), 64'd2);

    // 2: read slave 2 with three wait states, strobes forced 0
    wait_cfg[2] = 3;
    send(1'b0, 32'h0000_2000, 32'h0, 4'hF, 3'd0,
         mk(4'b0100, 32'h0000_2000, 32'h0, 4'h0,
            1'b0, 4, 32'h1234_5678, 1'b0, 1'b0));
    drain(30);

    // 3: five commands, FIFO fills behind slow slaves
    for (int i = 0; i < 4; i++) wait_cfg[i] = 3;
    send(1'b1, 32'h0000_0010, 32'h1, 4'h3, 3'd0,
         mk(4'b0001, 32'h10, 32'h1, 4'h3,
            1'b1, 4, 32'h0, 1'b0, 1'b0));
    send(1'b0, 32'h0000_1020, 32'h0, 4'h0, 3'd1,
         mk(4'b0010, 32'h1020, 32'h0, 4'h0,
            1'b0, 4, 32'hB1B1_1111, 1'b0, 1'b0));
    send(1'b0, 32'h0000_3030, 32'h0, 4'h0, 3'd3,
         mk(4'b1000, 32'h3030, 32'h0, 4'h0,
            1'b0, 4, 32'hC3C3_3333, 1'b0, 1'b0));
    send(1'b1, 32'h0000_2040, 32'h55AA_55AA, 4'hC, 3'd0,
         mk(4'b0100, 32'h2040, 32'h55AA_55AA, 4'hC,
            1'b1, 4, 32'h0, 1'b0, 1'b0));
    send(1'b0, 32'h0000_0050, 32'h0, 4'h0, 3'd0,
         mk(4'b0001, 32'h50, 32'h0, 4'h0,
            1'b0, 4, 32'hA0A0_0000, 1'b0, 1'b0));
    chk("fifo_full_ready", 64'(bus.cmd_ready), 64'd0);
    drain(200);
    for (int i = 0; i < 4; i++) wait_cfg[i] = 0;

    // 4: slave 0 never ready, times out after 16 ACCESS cycles
    hang[0] = 1'b1;
    send(1'b0, 32'h0000_0100, 32'h0, 4'h0, 3'd0,
         mk(4'b0001, 32'h100, 32'h0, 4'h0,
            1'b0, 16, 32'h0, 1'b1, 1'b1));
    drain(60);
    hang[0] = 1'b0;

    // 5: PSLVERR from slave 3, response held by back-pressure
    err_cfg[3] = 1'b1;
    bus.rsp_ready = 1'b0;
    send(1'b0, 32'h0000_3008, 32'h0, 4'h0, 3'd0,
         mk(4'b1000, 32'h3008, 32'h0, 4'h0,
            1'b0, 1, 32'h0, 1'b1, 1'b0));
    send(1'b1, 32'h0000_1100, 32'h0BAD_F00D, 4'h1, 3'd0,
         mk(4'b0010, 32'h1100, 32'h0BAD_F00D, 4'h1,
            1'b1, 1, 32'h0, 1'b0, 1'b0));
    n = 0;
    while (!bus.rsp_valid && n < 20) begin
      cyc();
      n++;
    end
    chk("hold_rsp_seen", 64'(bus.rsp_valid), 64'd1);
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("hold_rsp", {61'd0, bus.rsp_valid, bus.rsp_err,
          bus.rsp_timeout}, 64'd6);
      chk("hold_no_setup", 64'(bus.PSEL), 64'd0);
    end
    bus.rsp_ready = 1'b1;
    drain(30);
    err_cfg[3] = 1'b0;

    // 6: reset mid-ACCESS with two queued commands
    hang[0] = 1'b1;
    send(1'b0, 32'h0000_0200, 32'h0, 4'h0, 3'd0,
         mk(4'b0001, 32'h200, 32'h0, 4'h0,
            1'b0, 1, 32'h0, 1'b0, 1'b0));
    send(1'b0, 32'h0000_0204, 32'h0, 4'h0, 3'd0,
         mk(4'b0001, 32'h204, 32'h0, 4'h0,
            1'b0, 1, 32'h0, 1'b0, 1'b0));
    send(1'b0, 32'h0000_0208, 32'h0, 4'h0, 3'd0,
         mk(4'b0001, 32'h208, 32'h0, 4'h0,
            1'b0, 1, 32'h0, 1'b0, 1'b0));
    n = 0;
    while (!bus.PENABLE && n < 20) begin
      cyc();
      n++;
    end
    chk("pre_rst_access", 64'(bus.PENABLE), 64'd1);
    rstn = 1'b1;
    cyc();
    exp_q.delete();
    chk("mid_rst_bus", {59'd0, bus.PSEL, bus.PENABLE}, 64'd0);
    chk("mid_rst_rsp", 64'(bus.rsp_valid), 64'd0);
    chk("mid_rst_ready", 64'(bus.cmd_ready), 64'd0);
    chk("mid_rst_paddr", 64'(bus.PADDR), 64'd0);
    hang[0] = 1'b0;
    rstn = 1'b0;
    cyc();
    chk("rel_ready", 64'(bus.cmd_ready), 64'd1);
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      if (bus.PSEL != 0 || bus.rsp_valid) seen++;
    end
    chk("flushed_fifo", 64'(seen), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=done");
    $fatal(1, "watchdog");
  end
endmodule
